miss_fill_arbiter: RTL and testbench

MISS_FILL_ARBITER -- requirements
Module: miss_fill_arbiter

---
 rtl/miss_fill_arbiter_if.sv | 54 +++++
 rtl/miss_fill_arbiter.sv | 129 ++++++++++++
 tb/tb_miss_fill_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miss_fill_arbiter_if.sv
// Miss/fill bundle between the I/D caches, the fill arbiter and main memory.
// Memory read data itself bypasses this block; only its valid strobe is seen here.
interface miss_fill_arbiter_if #(
    parameter int AWIDTH = 16
);
    logic              d_miss_detected;
    logic [AWIDTH-1:0] d_miss_address;
    logic              i_miss_detected;
    logic [AWIDTH-1:0] i_miss_address;
    logic              memory_data_valid;
    logic [AWIDTH-1:0] memory_address;
    logic              memory_enable;
    logic [AWIDTH-1:0] fill_address;
    logic              d_fsm_data_wen;
    logic              d_fsm_tag_wen;
    logic              i_fsm_data_wen;
    logic              i_fsm_tag_wen;
    logic              d_stall;
    logic              i_stall;

    modport slave (
        input  d_miss_detected,
        input  d_miss_address,
        input  i_miss_detected,
        input  i_miss_address,
        input  memory_data_valid,
        output memory_address,
        output memory_enable,
        output fill_address,
        output d_fsm_data_wen,
        output d_fsm_tag_wen,
        output i_fsm_data_wen,
        output i_fsm_tag_wen,
        output d_stall,
        output i_stall
    );

    modport master (
        output d_miss_detected,
        output d_miss_address,
        output i_miss_detected,
        output i_miss_address,
        output memory_data_valid,
        input  memory_address,
        input  memory_enable,
        input  fill_address,
        input  d_fsm_data_wen,
        input  d_fsm_tag_wen,
        input  i_fsm_data_wen,
        input  i_fsm_tag_wen,
        input  d_stall,
        input  i_stall
    );
endinterface

// File: rtl/miss_fill_arbiter.sv
// Arbitrates I/D cache misses onto one memory port and sequences the block
// fill: issues BLOCK_WORDS reads, steers returning words, then writes the tag.
module miss_fill_arbiter #(
    parameter int AWIDTH      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    miss_fill_arbiter_if.slave bus
);
    localparam int CW = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [AWIDTH-1:0] BASE_MASK =
        ~AWIDTH'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [CW-1:0]     issue_q, issue_d;
    logic [CW-1:0]     recv_q, recv_d;

    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [AWIDTH-1:0] fill_addr;
    logic              d_wen, d_tag, i_wen, i_tag;
    logic              busy;
    logic              d_stall_w;
    logic [AWIDTH-1:0] issue_off;
    logic [AWIDTH-1:0] recv_off;

    // owner_q: 0 = D-cache, 1 = I-cache
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    assign issue_off = AWIDTH'({issue_q, 1'b0});
    assign recv_off  = AWIDTH'({recv_q, 1'b0});

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        issue_d   = issue_q;
        recv_d    = recv_q;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_addr = '0;
        d_wen     = 1'b0;
        d_tag     = 1'b0;
        i_wen     = 1'b0;
        i_tag     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.d_miss_detected) begin
                    owner_d = 1'b0;
                    base_d  = bus.d_miss_address & BASE_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = S_FILL;
                end else if (bus.i_miss_detected) begin
                    owner_d = 1'b1;
                    base_d  = bus.i_miss_address & BASE_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (issue_q != FULL) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + issue_off;
                    issue_d  = issue_q + 1'b1;
                end
                fill_addr = base_q + recv_off;
                // Extra strobes past the last word never reach the arrays
                if (bus.memory_data_valid && recv_q != FULL) begin
                    d_wen  = ~owner_q;
                    i_wen  = owner_q;
                    recv_d = recv_q + 1'b1;
                    if (recv_q == LAST) begin
                        d_tag   = ~owner_q;
                        i_tag   = owner_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign d_stall_w = bus.d_miss_detected | (busy & ~owner_q);

    assign bus.memory_enable  = mem_en;
    assign bus.memory_address = mem_addr;
    assign bus.fill_address   = fill_addr;
    assign bus.d_fsm_data_wen = d_wen;
    assign bus.d_fsm_tag_wen  = d_tag;
    assign bus.i_fsm_data_wen = i_wen;
    assign bus.i_fsm_tag_wen  = i_tag;
    assign bus.d_stall        = d_stall_w;
    // IF must hold during any fill since the shared port is busy
    assign bus.i_stall = bus.i_miss_detected | d_stall_w
                       | (busy & owner_q);
endmodule

// File: tb/tb_miss_fill_arbiter.sv
// Bench for miss_fill_arbiter: directed fill table, hand sequences for
// reset/spurious cases, and random traffic against a transaction model.
module tb_miss_fill_arbiter;
    localparam int BW = 8;

    logic clk;
    logic rst;

    miss_fill_arbiter_if #(.AWIDTH(16)) mif ();

    miss_fill_arbiter #(
        .AWIDTH     (16),
        .BLOCK_WORDS(BW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // model: phase 0 idle, 1 filling, 2 done
    int m_phase, m_own, m_base, m_nis, m_nrc;

    // memory responder
    bit pipe [16];
    int lat;

    // per-transaction observations
    int st_rd_n, st_dw, st_iw, st_dt, st_it, st_nostall;
    logic [15:0] st_first_rd, st_last_rd, st_first_fa, st_last_fa;
    bit tag_this;

    typedef struct {
        bit          d;
        logic [15:0] da;
        bit          i;
        logic [15:0] ia;
        int          lat;
        int          drop;
        bit          spur;
        bit          keep;
        bit          own_i;
        logic [15:0] base;
    } fv_t;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_own   = 0;
        m_base  = 0;
        m_nis   = 0;
        m_nrc   = 0;
    endtask

    task automatic clear_stats();
        st_rd_n = 0; st_dw = 0; st_iw = 0;
        st_dt = 0; st_it = 0; st_nostall = 0;
        st_first_rd = '0; st_last_rd = '0;
        st_first_fa = '0; st_last_fa = '0;
    endtask

    task automatic tick();
        logic dm, im, v, r, busy;
        logic [15:0] da, ia;
        logic e_men, act, last;
        logic e_dw, e_iw, e_dt, e_it, e_ds, e_is;
        logic [15:0] e_ma, e_fa;
        logic [38:0] got, exp;
        bit pv;
        @(negedge clk);
        dm = mif.d_miss_detected;
        da = mif.d_miss_address;
        im = mif.i_miss_detected;
        ia = mif.i_miss_address;
        v  = mif.memory_data_valid;
        r  = rst;
        if (r) model_reset();
        busy  = (m_phase != 0);
        e_men = (m_phase == 1) && (m_nis < BW);
        e_ma  = e_men ? 16'(m_base + 2 * m_nis) : 16'h0;
        e_fa  = (m_phase == 1) ? 16'(m_base + 2 * m_nrc) : 16'h0;
        act   = (m_phase == 1) && v;
        last  = act && (m_nrc == BW - 1);
        e_dw  = act && (m_own == 0);
        e_iw  = act && (m_own == 1);
        e_dt  = last && (m_own == 0);
        e_it  = last && (m_own == 1);
        e_ds  = dm || (busy && m_own == 0);
        e_is  = im || e_ds || (busy && m_own == 1);
        exp = {e_men, e_ma, e_fa, e_dw, e_dt, e_iw, e_it, e_ds, e_is};
        got = {mif.memory_enable, mif.memory_address, mif.fill_address,
               mif.d_fsm_data_wen, mif.d_fsm_tag_wen,
               mif.i_fsm_data_wen, mif.i_fsm_tag_wen,
               mif.d_stall, mif.i_stall};
        chk("cyc_outputs", 64'(got), 64'(exp));
        if (mif.memory_enable) begin
            if (st_rd_n == 0) st_first_rd = mif.memory_address;
            st_last_rd = mif.memory_address;
            st_rd_n++;
        end
        if (mif.d_fsm_data_wen || mif.i_fsm_data_wen) begin
            if (st_dw + st_iw == 0) st_first_fa = mif.fill_address;
            st_last_fa = mif.fill_address;
        end
        st_dw += int'(mif.d_fsm_data_wen);
        st_iw += int'(mif.i_fsm_data_wen);
        st_dt += int'(mif.d_fsm_tag_wen);
        st_it += int'(mif.i_fsm_tag_wen);
        tag_this = mif.d_fsm_tag_wen || mif.i_fsm_tag_wen;
        if (busy && !mif.i_stall) st_nostall++;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (dm || im) begin
                        m_own   = dm ? 0 : 1;
                        m_base  = int'((dm ? da : ia) & 16'(~(2 * BW - 1)));
                        m_nis   = 0;
                        m_nrc   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (e_men) m_nis++;
                    if (act) m_nrc++;
                    if (last) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        pv = pipe[0];
        for (int k = 0; k < 15; k++) pipe[k] = pipe[k + 1];
        pipe[15] = 1'b0;
        if (e_men) pipe[lat - 1] = 1'b1;
        #1;
        mif.memory_data_valid = pv;
    endtask

    task automatic run_fill(input fv_t fv);
        bit seen;
        clear_stats();
        lat = fv.lat;
        mif.d_miss_detected = fv.d;
        mif.d_miss_address  = fv.da;
        mif.i_miss_detected = fv.i;
        mif.i_miss_address  = fv.ia;
        seen = 0;
        for (int n = 1; n <= 300 && !seen; n++) begin
            tick();
            if (n == fv.drop || tag_this) begin
                if (fv.own_i) mif.i_miss_detected = 1'b0;
                else mif.d_miss_detected = 1'b0;
            end
            if (tag_this) begin
                seen = 1;
                if (!fv.keep) begin
                    mif.d_miss_detected = 1'b0;
                    mif.i_miss_detected = 1'b0;
                end
            end
        end
        chk("fill_done_in_time", 64'(seen), 64'd1);
        if (fv.spur) mif.memory_data_valid = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_fill(input string nm, input fv_t fv);
        chk({nm, "_reads"}, 64'(st_rd_n), 64'(BW));
        chk({nm, "_first_rd"}, 64'(st_first_rd), 64'(fv.base));
        chk({nm, "_last_rd"}, 64'(st_last_rd), 64'(16'(fv.base + 14)));
        chk({nm, "_first_fa"}, 64'(st_first_fa), 64'(fv.base));
        chk({nm, "_last_fa"}, 64'(st_last_fa), 64'(16'(fv.base + 14)));
        chk({nm, "_own_wen"}, 64'(fv.own_i ? st_iw : st_dw), 64'(BW));
        chk({nm, "_oth_wen"}, 64'(fv.own_i ? st_dw : st_iw), 64'd0);
        chk({nm, "_own_tag"}, 64'(fv.own_i ? st_it : st_dt), 64'd1);
        chk({nm, "_oth_tag"}, 64'(fv.own_i ? st_dt : st_it), 64'd0);
    endtask

    fv_t tbl[6];
    fv_t fa, fb;

    initial begin
        checks = 0;
        failures = 0;
        lat = 4;
        foreach (pipe[k]) pipe[k] = 1'b0;
        model_reset();
        clear_stats();
        rst = 1'b1;
        mif.d_miss_detected   = 1'b0;
        mif.d_miss_address    = '0;
        mif.i_miss_detected   = 1'b0;
        mif.i_miss_address    = '0;
        mif.memory_data_valid = 1'b0;

        //                d  da        i  ia       lat drop spur keep own base
        tbl[0] = '{1, 16'h1236, 0, 16'h0000, 4, 0, 0, 0, 0, 16'h1230};
        tbl[1] = '{0, 16'h0000, 1, 16'hFFF0, 3, 3, 0, 0, 1, 16'hFFF0};
        tbl[2] = '{1, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 0, 0, 16'hFFF0};
        tbl[3] = '{0, 16'h0000, 1, 16'h1234, 7, 0, 0, 0, 1, 16'h1230};
        tbl[4] = '{1, 16'h000F, 1, 16'h4444, 2, 0, 0, 0, 0, 16'h0000};
        tbl[5] = '{1, 16'h3008, 0, 16'h0000, 4, 0, 1, 0, 0, 16'h3000};

        // reset state, stalls follow miss inputs only
        mif.d_miss_detected = 1'b1;
        tick();
        chk("rst_d_stall", 64'(mif.d_stall), 64'd1);
        chk("rst_i_stall", 64'(mif.i_stall), 64'd1);
        chk("rst_mem_en", 64'(mif.memory_enable), 64'd0);
        chk("rst_mem_addr", 64'(mif.memory_address), 64'd0);
        mif.d_miss_detected = 1'b0;
        tick();
        chk("rst_d_stall_lo", 64'(mif.d_stall), 64'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            run_fill(tbl[k]);
            check_fill($sformatf("vec%0d", k), tbl[k]);
            repeat (3) tick();
        end

        // simultaneous D and I: D first with IF held, then I
        fa = '{1, 16'h0040, 1, 16'h2002, 4, 0, 0, 1, 0, 16'h0040};
        fb = '{0, 16'h0000, 1, 16'h2002, 4, 0, 0, 0, 1, 16'h2000};
        run_fill(fa);
        check_fill("dual_d", fa);
        chk("dual_i_stall_held", 64'(st_nostall), 64'd0);
        run_fill(fb);
        check_fill("dual_i", fb);
        repeat (3) tick();

        // reset during I fill after third returned word
        clear_stats();
        lat = 4;
        mif.i_miss_detected = 1'b1;
        mif.i_miss_address  = 16'h0100;
        for (int n = 0; n < 100 && st_iw < 3; n++) tick();
        chk("abort_wen3", 64'(st_iw), 64'd3);
        rst = 1'b1;
        mif.i_miss_detected = 1'b0;
        #1;
        chk("abort_async", {mif.memory_enable, mif.fill_address,
                            mif.i_fsm_data_wen, mif.i_stall}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_no_more_wen", 64'(st_iw), 64'd3);
        chk("abort_no_tag", 64'(st_it), 64'd0);

        // spurious valids in idle
        clear_stats();
        repeat (4) begin
            mif.memory_data_valid = 1'b1;
            tick();
        end
        chk("spur_idle_wen", 64'(st_dw + st_iw), 64'd0);
        chk("spur_idle_rd", 64'(st_rd_n), 64'd0);

        // random traffic against the model
        lat = 1 + int'($urandom_range(0, 6));
        clear_stats();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                mif.d_miss_detected = ~mif.d_miss_detected;
                mif.d_miss_address  = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                mif.i_miss_detected = ~mif.i_miss_detected;
                mif.i_miss_address  = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) mif.memory_data_valid = 1'b1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
